// File: rtl/dsp_pkg.sv
// Shared definitions for the DSP48A1 control slice: group FSM states,
// token sideband carried alongside each operand pair, and Z-mux opmode codes.
package dsp_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,   // next accepted token opens a new group
      ACCUM = 1'b1    // inside a group, next token accumulates
   } grp_state_e;

   typedef struct packed {
      logic valid;    // a real operand token occupies this stage
      logic first;    // token opens its accumulation group
      logic last;     // token closes its accumulation group
   } tok_t;

   // OPMODE[3:2] Z-mux encodings used by the slice top
   localparam logic [1:0] OPMODE_Z_ZERO = 2'b00;
   localparam logic [1:0] OPMODE_Z_PCIN = 2'b01;
   localparam logic [1:0] OPMODE_Z_P    = 2'b10;
   localparam logic [1:0] OPMODE_Z_C    = 2'b11;

endpackage

// File: rtl/dsp_tok_pipe.sv
// Token sideband shift register mirroring the datapath register depth.
// Stage 0 is the first register after acceptance; stage DEPTH-1 is P.
module dsp_tok_pipe
   import dsp_pkg::*;
#(
   parameter int DEPTH = 3
)
(
   input  logic               clk,
   input  logic               rst,
   input  logic               clear,
   input  logic               adv,
   input  tok_t               in_tok,
   output tok_t [DEPTH-1:0]   tok_q
);

   tok_t [DEPTH-1:0] pipe_r;

   // Shift one stage per advance; clear discards every in-flight token
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pipe_r <= '0;
      end else if (clear) begin
         pipe_r <= '0;
      end else if (adv) begin
         pipe_r[0] <= in_tok;
         for (int i = 1; i < DEPTH; i++) begin
            pipe_r[i] <= pipe_r[i-1];
         end
      end else begin
         pipe_r <= pipe_r;
      end
   end

   assign tok_q = pipe_r;

endmodule

// File: rtl/dsp_pipe_ctrl.sv
// Control-side initiator for the DSP48A1 datapath: per-stage clock enables,
// sync clear and Z/accumulate select, with valid/ready on both sides.
// Carries no data; operand tokens are tracked as sideband only.
module dsp_pipe_ctrl
   import dsp_pkg::*;
#(
   parameter int AREG  = 1,
   parameter int MREG  = 1,
   parameter int PREG  = 1,
   parameter int CNT_W = 8
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   input  logic             in_last,
   output logic             in_ready,
   output logic             ce_ab,
   output logic             ce_m,
   output logic             ce_p,
   output logic             rst_dp,
   output logic             sel_ab,
   output logic             sel_m,
   output logic             z_acc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] out_cnt
);

   localparam int LAT = AREG + MREG + 1;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   // Accumulation lives in P, so a bypassed P stage cannot work
   generate
      if (PREG != 1) begin : g_preg_chk
         $error("dsp_pipe_ctrl: PREG must be 1");
      end
   endgenerate

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (v == CNT_MAX) return v;
      else              return v + CNT_ONE;
   endfunction

   tok_t [LAT-1:0]   tok_s;
   tok_t             in_tok_s;
   tok_t             m_in_tok_s;
   tok_t             p_in_tok_s;
   grp_state_e       state_r;
   grp_state_e       state_nxt_s;
   logic [CNT_W-1:0] cnt_r;
   logic             stall_s;
   logic             adv_s;
   logic             accept_s;
   logic             ce_p_s;
   logic             unused_tok_s;

   // A completed sum in P that downstream refuses freezes the whole pipe
   assign stall_s  = tok_s[LAT-1].valid & tok_s[LAT-1].last & ~out_ready;
   assign adv_s    = ~stall_s & ~flush;
   assign in_ready = adv_s & ~rst;
   assign accept_s = in_valid & in_ready;

   // Sideband of the token entering the pipe; a bubble is all-zero
   always_comb begin
      in_tok_s       = '0;
      in_tok_s.valid = accept_s;
      in_tok_s.first = accept_s & (state_r == IDLE);
      in_tok_s.last  = accept_s & in_last;
   end

   dsp_tok_pipe #(.DEPTH(LAT)) u_tok_pipe (
      .clk    (clk),
      .rst    (rst),
      .clear  (flush),
      .adv    (adv_s),
      .in_tok (in_tok_s),
      .tok_q  (tok_s)
   );

   // Token at each stage's input: a bypassed stage sees the live upstream token
   generate
      if (AREG != 0) begin : g_m_in_reg
         assign m_in_tok_s = tok_s[0];
      end else begin : g_m_in_byp
         assign m_in_tok_s = in_tok_s;
      end
      if (LAT >= 2) begin : g_p_in_reg
         assign p_in_tok_s = tok_s[LAT-2];
      end else begin : g_p_in_byp
         assign p_in_tok_s = in_tok_s;
      end
   endgenerate

   assign ce_ab     = accept_s;
   assign ce_m      = adv_s & m_in_tok_s.valid;
   assign ce_p_s    = adv_s & p_in_tok_s.valid;
   assign ce_p      = ce_p_s;
   assign z_acc     = ce_p_s & ~p_in_tok_s.first;
   assign rst_dp    = flush & ~rst;
   assign sel_ab    = (AREG != 0) ? 1'b1 : 1'b0;
   assign sel_m     = (MREG != 0) ? 1'b1 : 1'b0;
   assign out_valid = tok_s[LAT-1].valid & tok_s[LAT-1].last;
   assign out_cnt   = cnt_r;

   // Sideband fields the control decode does not consume
   assign unused_tok_s = ^{tok_s, m_in_tok_s.first, m_in_tok_s.last, p_in_tok_s.last};

   // Group tracking: a last token returns to IDLE, any other keeps accumulating
   always_comb begin
      state_nxt_s = state_r;
      if (accept_s) begin
         case (state_r)
            IDLE:    state_nxt_s = in_last ? IDLE : ACCUM;
            ACCUM:   state_nxt_s = in_last ? IDLE : ACCUM;
            default: state_nxt_s = IDLE;
         endcase
      end else begin
         state_nxt_s = state_r;
      end
   end

   // Group state register; flush abandons a partial group
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else if (flush) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Products summed in P: restart on a first token, saturate otherwise
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r <= '0;
      end else if (flush) begin
         cnt_r <= '0;
      end else if (ce_p_s) begin
         cnt_r <= p_in_tok_s.first ? CNT_ONE : sat_inc(cnt_r);
      end else begin
         cnt_r <= cnt_r;
      end
   end

endmodule
